// File: rtl/ntt_n_pkg.sv
// Shared constants for the N-point number-theoretic transform engine:
// default sizing, derived ring/table sizes and the controller state encoding.
package ntt_n_pkg;

    localparam int DATA_SIZE_ARB = 16;
    localparam int RING_DEPTH    = 3;
    localparam int PE_DEPTH      = 1;
    localparam int RING_SIZE     = 1 << RING_DEPTH;
    localparam int TW            = ((2 ** (RING_DEPTH - PE_DEPTH) - 1) + PE_DEPTH) * (2 ** PE_DEPTH);

    // Top-level controller states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_W  = 3'd1;
    localparam logic [2:0] ST_LOAD_D  = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_OUTPUT  = 3'd4;

    // Sub-phases of COMPUTE
    localparam logic [1:0] PH_BREV  = 2'd0;
    localparam logic [1:0] PH_BFLY  = 2'd1;
    localparam logic [1:0] PH_SCALE = 2'd2;

    // Twiddle table length for a given ring depth and PE depth
    function automatic int tw_len(input int ring_depth, input int pe_depth);
        return ((2 ** (ring_depth - pe_depth) - 1) + pe_depth) * (2 ** pe_depth);
    endfunction

endpackage

// File: rtl/ntt_n_mod_mul.sv
// Two-stage modular multiplier: r = a*b mod q, valid travels with the data.
// Stage 0 forms the full double-width product, stage 1 reduces it.
module ntt_n_mod_mul #(
    parameter int DATA_SIZE_ARB = ntt_n_pkg::DATA_SIZE_ARB
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_vld,
    input  logic [DATA_SIZE_ARB-1:0] a,
    input  logic [DATA_SIZE_ARB-1:0] b,
    input  logic [DATA_SIZE_ARB-1:0] q,
    output logic                     out_vld,
    output logic [DATA_SIZE_ARB-1:0] r
);
    import ntt_n_pkg::*;

    localparam int W = DATA_SIZE_ARB;

    logic [2*W-1:0] prod_p0_d, prod_p0_q;
    logic [W-1:0]   q_p0_d, q_p0_q;
    logic           vld_p0_d, vld_p0_q;
    logic [W-1:0]   res_p1_d, res_p1_q;
    logic           vld_p1_d, vld_p1_q;

    function automatic logic [W-1:0] reduce_mod(input logic [2*W-1:0] p, input logic [W-1:0] m);
        return W'(p % {{W{1'b0}}, m});
    endfunction

    // Next-state for both pipeline stages
    always_comb begin
        // stage 0: full-width product
        prod_p0_d = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        q_p0_d    = q;
        vld_p0_d  = in_vld;
        // stage 1: reduction into [0, q-1]
        res_p1_d  = reduce_mod(prod_p0_q, q_p0_q);
        vld_p1_d  = vld_p0_q;
    end

    // Valid pipeline, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
        end else begin
            vld_p0_q <= vld_p0_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    // Data pipeline, never reset
    always_ff @(posedge clk) begin
        prod_p0_q <= prod_p0_d;
        q_p0_q    <= q_p0_d;
        res_p1_q  <= res_p1_d;
    end

    assign out_vld = vld_p1_q;
    assign r       = res_p1_q;

endmodule

// File: rtl/ntt_n.sv
// Iterative radix-2 NTT / inverse NTT over a single in-place data RAM.
// Flow: load tables, load coefficients, then a transform runs a bit-reverse
// permutation, log2(N) butterfly stages and (inverse only) n_inv scaling,
// then streams the natural-order result after a one-cycle done pulse.
module ntt_n #(
    parameter int DATA_SIZE_ARB = ntt_n_pkg::DATA_SIZE_ARB,
    parameter int RING_DEPTH    = ntt_n_pkg::RING_DEPTH,
    parameter int PE_DEPTH      = ntt_n_pkg::PE_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_w,
    input  logic                     load_data,
    input  logic                     start,
    input  logic                     start_intt,
    input  logic [DATA_SIZE_ARB-1:0] din,
    output logic                     done,
    output logic [DATA_SIZE_ARB-1:0] dout
);
    import ntt_n_pkg::*;

    localparam int W     = DATA_SIZE_ARB;
    localparam int NSZ   = 1 << RING_DEPTH;
    localparam int TWL   = tw_len(RING_DEPTH, PE_DEPTH);
    localparam int AW    = RING_DEPTH;
    localparam int TAW   = $clog2(TWL);
    localparam int CNT_W = $clog2(2 * TWL + NSZ + 4);

    // Control state
    logic [2:0]       state_d, state_q;
    logic [1:0]       phase_d, phase_q;
    logic             inv_d, inv_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] wcnt_d, wcnt_q;
    logic [CNT_W-1:0] stg_d, stg_q;
    logic [1:0]       bstep_d, bstep_q;
    logic             done_d, done_q;
    logic [W-1:0]     dout_d, dout_q;

    // Storage (never reset)
    logic [W-1:0] q_d, q_q;
    logic [W-1:0] ninv_d, ninv_q;
    logic [W-1:0] data_ram_q [NSZ];
    logic [W-1:0] w_ram_q    [TWL];
    logic [W-1:0] winv_ram_q [TWL];

    // RAM write ports
    logic          we_a, we_b, tw_we, winv_we;
    logic [AW-1:0] addr_a, addr_b;
    logic [W-1:0]  wd_a, wd_b;
    logic [TAW-1:0] tw_waddr;

    // Butterfly addressing
    logic [AW-1:0]  cur_addr, rev_addr, i0_addr, i1_addr;
    logic [TAW-1:0] tw_idx;
    logic [W-1:0]   u_val, v_val, twiddle;

    // Multiplier hookup
    logic         mm_in_vld, mm_out_vld;
    logic [W-1:0] mm_a, mm_b, mm_r;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        logic [AW-1:0] y;
        for (int i = 0; i < AW; i++) y[i] = x[AW-1-i];
        return y;
    endfunction

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + {1'b0, m} - {1'b0, y};
        return s[W-1:0];
    endfunction

    ntt_n_mod_mul #(.DATA_SIZE_ARB(W)) u_mod_mul (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (mm_in_vld),
        .a       (mm_a),
        .b       (mm_b),
        .q       (q_q),
        .out_vld (mm_out_vld),
        .r       (mm_r)
    );

    // Butterfly pair and twiddle index for (stage, butterfly) = (stg_q, cnt_q)
    always_comb begin
        int s, b, j, base;
        s        = int'(stg_q);
        b        = int'(cnt_q);
        j        = b & ((1 << s) - 1);
        base     = ((b >> s) << (s + 1)) | j;
        i0_addr  = AW'(base);
        i1_addr  = AW'(base + (1 << s));
        tw_idx   = TAW'(j << (RING_DEPTH - 1 - s));
        cur_addr = AW'(cnt_q);
        rev_addr = bitrev(cur_addr);
        u_val    = data_ram_q[i0_addr];
        v_val    = data_ram_q[i1_addr];
        twiddle  = inv_q ? winv_ram_q[tw_idx] : w_ram_q[tw_idx];
    end

    // Controller: command decode, loads, compute sequencing and output stream
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        inv_d     = inv_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        stg_d     = stg_q;
        bstep_d   = bstep_q;
        done_d    = 1'b0;
        dout_d    = '0;
        q_d       = q_q;
        ninv_d    = ninv_q;
        we_a      = 1'b0;
        we_b      = 1'b0;
        addr_a    = '0;
        addr_b    = '0;
        wd_a      = '0;
        wd_b      = '0;
        tw_we     = 1'b0;
        winv_we   = 1'b0;
        tw_waddr  = '0;
        mm_in_vld = 1'b0;
        mm_a      = '0;
        mm_b      = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (load_w) begin
                    state_d = ST_LOAD_W;
                end else if (load_data) begin
                    state_d = ST_LOAD_D;
                end else if (start || start_intt) begin
                    state_d = ST_COMPUTE;
                    inv_d   = !start;
                    phase_d = PH_BREV;
                    stg_d   = '0;
                    bstep_d = '0;
                    wcnt_d  = '0;
                end
            end

            ST_LOAD_W: begin
                if (cnt_q < CNT_W'(TWL)) begin
                    tw_we    = 1'b1;
                    tw_waddr = TAW'(cnt_q);
                end else if (cnt_q < CNT_W'(2 * TWL)) begin
                    winv_we  = 1'b1;
                    tw_waddr = TAW'(cnt_q - CNT_W'(TWL));
                end else if (cnt_q == CNT_W'(2 * TWL)) begin
                    q_d = din;
                end else begin
                    ninv_d = din;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(2 * TWL + 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_LOAD_D: begin
                we_a   = 1'b1;
                addr_a = cur_addr;
                wd_a   = din;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NSZ - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_COMPUTE: begin
                case (phase_q)
                    PH_BREV: begin
                        // swap each pair once, from its lower index
                        if (cur_addr < rev_addr) begin
                            we_a   = 1'b1;
                            addr_a = cur_addr;
                            wd_a   = data_ram_q[rev_addr];
                            we_b   = 1'b1;
                            addr_b = rev_addr;
                            wd_b   = data_ram_q[cur_addr];
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(NSZ - 1)) begin
                            phase_d = PH_BFLY;
                            cnt_d   = '0;
                        end
                    end

                    PH_BFLY: begin
                        // one butterfly every three cycles: issue, wait, write back
                        if (bstep_q == 2'd0) begin
                            mm_in_vld = 1'b1;
                            mm_a      = v_val;
                            mm_b      = twiddle;
                            bstep_d   = 2'd1;
                        end else if (bstep_q == 2'd1) begin
                            bstep_d = 2'd2;
                        end else if (mm_out_vld) begin
                            we_a    = 1'b1;
                            addr_a  = i0_addr;
                            wd_a    = mod_add(u_val, mm_r, q_q);
                            we_b    = 1'b1;
                            addr_b  = i1_addr;
                            wd_b    = mod_sub(u_val, mm_r, q_q);
                            bstep_d = 2'd0;
                            cnt_d   = cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(NSZ / 2 - 1)) begin
                                cnt_d = '0;
                                if (stg_q == CNT_W'(RING_DEPTH - 1)) begin
                                    if (inv_q) begin
                                        phase_d = PH_SCALE;
                                        wcnt_d  = '0;
                                    end else begin
                                        state_d = ST_OUTPUT;
                                        done_d  = 1'b1;
                                    end
                                end else begin
                                    stg_d = stg_q + 1'b1;
                                end
                            end
                        end
                    end

                    default: begin
                        // inverse only: multiply every word by n_inv, fully pipelined
                        if (cnt_q < CNT_W'(NSZ)) begin
                            mm_in_vld = 1'b1;
                            mm_a      = data_ram_q[cur_addr];
                            mm_b      = ninv_q;
                            cnt_d     = cnt_q + 1'b1;
                        end
                        if (mm_out_vld) begin
                            we_a   = 1'b1;
                            addr_a = AW'(wcnt_q);
                            wd_a   = mm_r;
                            wcnt_d = wcnt_q + 1'b1;
                            if (wcnt_q == CNT_W'(NSZ - 1)) begin
                                state_d = ST_OUTPUT;
                                done_d  = 1'b1;
                                cnt_d   = '0;
                            end
                        end
                    end
                endcase
            end

            ST_OUTPUT: begin
                // words 0..N-1, then one extra cycle to return dout to 0
                if (cnt_q < CNT_W'(NSZ)) begin
                    dout_d = data_ram_q[cur_addr];
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_BREV;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            stg_q   <= '0;
            bstep_q <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            stg_q   <= stg_d;
            bstep_q <= bstep_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    // Modulus, n_inv and RAM contents survive reset
    always_ff @(posedge clk) begin
        q_q    <= q_d;
        ninv_q <= ninv_d;
        if (we_a)    data_ram_q[addr_a]   <= wd_a;
        if (we_b)    data_ram_q[addr_b]   <= wd_b;
        if (tw_we)   w_ram_q[tw_waddr]    <= din;
        if (winv_we) winv_ram_q[tw_waddr] <= din;
    end

    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_ntt_n.sv
// Directed bench for ntt_n with N=8, q=17, w=2: table of load/transform
// vectors plus hand sequences for priority, ignored commands and reset.
module tb_ntt_n;

    localparam int BOUND = 8 / 2 * 3 * 4 + 2 * 8 + 64;
    localparam int NV    = 8;

    typedef struct packed {
        logic            inv;
        logic [7:0][15:0] a;
        logic [7:0][15:0] x;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        load_w;
    logic        load_data;
    logic        start;
    logic        start_intt;
    logic [15:0] din;
    logic        done;
    logic [15:0] dout;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs [NV];
    int   tw_w    [8] = '{1, 2, 4, 8, 3, 7, 11, 5};
    int   tw_winv [8] = '{1, 9, 13, 15, 6, 10, 2, 14};

    ntt_n dut (
        .clk        (clk),
        .reset      (reset),
        .load_w     (load_w),
        .load_data  (load_data),
        .start      (start),
        .start_intt (start_intt),
        .din        (din),
        .done       (done),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0][15:0] w8(input int e0, input int e1, input int e2, input int e3,
                                            input int e4, input int e5, input int e6, input int e7);
        logic [7:0][15:0] r;
        r[0] = 16'(e0); r[1] = 16'(e1); r[2] = 16'(e2); r[3] = 16'(e3);
        r[4] = 16'(e4); r[5] = 16'(e5); r[6] = 16'(e6); r[7] = 16'(e7);
        return r;
    endfunction

    task automatic set_vec(input int idx, input logic inv, input logic [7:0][15:0] a,
                           input logic [7:0][15:0] x);
        vecs[idx].inv = inv;
        vecs[idx].a   = a;
        vecs[idx].x   = x;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_tables();
        // load_data pulsed alongside: load_w must win
        load_w = 1'b1;
        load_data = 1'b1;
        tick();
        load_w = 1'b0;
        load_data = 1'b0;
        for (int i = 0; i < 8; i++) begin din = 16'(tw_w[i]); tick(); end
        for (int i = 0; i < 8; i++) begin din = 16'(tw_winv[i]); tick(); end
        din = 16'd17; tick();
        din = 16'd15; tick();
        din = '0;
    endtask

    // also_cmds: pulse start/start_intt with load_data; start_at: pulse start mid-load
    task automatic load_vec(input logic [7:0][15:0] a, input bit also_cmds, input int start_at);
        load_data = 1'b1;
        if (also_cmds) begin start = 1'b1; start_intt = 1'b1; end
        tick();
        load_data = 1'b0;
        start = 1'b0;
        start_intt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = a[i];
            if (i == start_at) start = 1'b1;
            tick();
            start = 1'b0;
        end
        din = '0;
    endtask

    // mode 0 forward, 1 inverse, 2 both pulses; lw_at pulses load_w while streaming
    task automatic run(input int mode, input logic [7:0][15:0] x, input int lw_at, input string nm);
        int cyc;
        start = (mode != 1);
        start_intt = (mode != 0);
        tick();
        start = 1'b0;
        start_intt = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < BOUND) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s done: not seen within %0d cycles", nm, BOUND);
            return;
        end
        for (int k = 0; k < 8; k++) begin
            if (k == lw_at) begin load_w = 1'b1; din = 16'd3; end
            tick();
            load_w = 1'b0;
            din = '0;
            check($sformatf("%s dout[%0d]", nm, k), dout, x[k]);
            if (k == 0) check($sformatf("%s done width", nm), {15'd0, done}, 16'd0);
        end
        tick();
        check($sformatf("%s dout idle", nm), dout, 16'd0);
    endtask

    initial begin
        bit bad;
        reset = 1'b0;
        load_w = 1'b0;
        load_data = 1'b0;
        start = 1'b0;
        start_intt = 1'b0;
        din = '0;

        set_vec(0, 1'b0, w8(1, 0, 0, 0, 0, 0, 0, 0),     w8(1, 1, 1, 1, 1, 1, 1, 1));
        set_vec(1, 1'b0, w8(0, 1, 0, 0, 0, 0, 0, 0),     w8(1, 2, 4, 8, 16, 15, 13, 9));
        set_vec(2, 1'b1, w8(1, 1, 1, 1, 1, 1, 1, 1),     w8(1, 0, 0, 0, 0, 0, 0, 0));
        set_vec(3, 1'b1, w8(1, 2, 4, 8, 16, 15, 13, 9),  w8(0, 1, 0, 0, 0, 0, 0, 0));
        set_vec(4, 1'b0, w8(1, 2, 3, 4, 5, 6, 7, 8),     w8(2, 8, 14, 6, 13, 3, 12, 1));
        set_vec(5, 1'b1, w8(2, 8, 14, 6, 13, 3, 12, 1),  w8(1, 2, 3, 4, 5, 6, 7, 8));
        set_vec(6, 1'b0, w8(16, 16, 16, 16, 16, 16, 16, 16), w8(9, 0, 0, 0, 0, 0, 0, 0));
        set_vec(7, 1'b0, w8(1, 1, 1, 1, 1, 1, 1, 1),     w8(8, 0, 0, 0, 0, 0, 0, 0));

        repeat (3) tick();
        check("reset done", {15'd0, done}, 16'd0);
        check("reset dout", dout, 16'd0);
        reset = 1'b1;
        tick();

        load_tables();

        for (int v = 0; v < NV; v++) begin
            load_vec(vecs[v].a, 1'b0, -1);
            run(vecs[v].inv ? 1 : 0, vecs[v].x, -1, $sformatf("vec%0d", v));
        end

        // load_data beats start/start_intt; start beats start_intt
        load_vec(w8(0, 1, 0, 0, 0, 0, 0, 0), 1'b1, -1);
        run(2, w8(1, 2, 4, 8, 16, 15, 13, 9), -1, "prio");

        // start during load and load_w during output are ignored
        load_vec(w8(1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 3);
        run(0, w8(1, 1, 1, 1, 1, 1, 1, 1), 3, "ignored");
        load_vec(w8(1, 2, 4, 8, 16, 15, 13, 9), 1'b0, -1);
        run(1, w8(0, 1, 0, 0, 0, 0, 0, 0), -1, "tables kept");

        // reset in the middle of the butterfly stages aborts the transform
        load_vec(w8(0, 1, 0, 0, 0, 0, 0, 0), 1'b0, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort done", {15'd0, done}, 16'd0);
        check("abort dout", dout, 16'd0);
        bad = 1'b0;
        repeat (150) begin
            tick();
            if (done !== 1'b0 || dout !== 16'd0) bad = 1'b1;
        end
        check("abort quiet", {15'd0, bad}, 16'd0);
        load_vec(w8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, -1);
        run(0, w8(2, 8, 14, 6, 13, 3, 12, 1), -1, "after reset");

        // transform again on the RAM contents left by the previous one
        run(0, w8(8, 13, 5, 14, 6, 15, 7, 16), -1, "no reload");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_n.md
NTT_N -- requirements
Module: ntt_n

Interface
REQ-001 Parameter DATA_SIZE_ARB, default 16: coefficient/modulus word width.
REQ-002 Parameter RING_DEPTH, default 3: log2 of ring size N.
REQ-003 Parameter PE_DEPTH, default 1: log2 of PE count P; fixes twiddle table length TW = ((2^(RING_DEPTH-PE_DEPTH)-1)+PE_DEPTH)*2^PE_DEPTH.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 load_w  input  1  one-cycle pulse; starts twiddle/constant load.
REQ-007 load_data  input  1  one-cycle pulse; starts coefficient load.
REQ-008 start  input  1  one-cycle pulse; starts forward NTT.
REQ-009 start_intt  input  1  one-cycle pulse; starts inverse NTT.
REQ-010 din  input  DATA_SIZE_ARB  load data stream.
REQ-011 done  output  1  one-cycle pulse; result stream follows.
REQ-012 dout  output  DATA_SIZE_ARB  result stream.

Function
REQ-013 States IDLE, LOAD_W, LOAD_D, COMPUTE, OUTPUT; commands accepted only in IDLE, ignored elsewhere.
REQ-014 Command priority in IDLE when several pulse together: load_w > load_data > start > start_intt.
REQ-015 LOAD_W: on the 2*TW+2 cycles after the load_w cycle, din carries W[0..TW-1], WINV[0..TW-1], q, n_inv, one word per cycle; then IDLE.
REQ-016 Table semantics: W[m]=w^m mod q, WINV[m]=w^-m mod q for 0<=m<N/2, w a primitive N-th root of unity mod q; entries m>=N/2 stored but unused.
REQ-017 LOAD_D: on the N cycles after the load_data cycle, din carries a[0..N-1] in natural order; then IDLE.
REQ-018 Forward: X[k] = sum_j a[j]*w^(jk) mod q, k=0..N-1.
REQ-019 Inverse: x[k] = n_inv * sum_j a[j]*w^(-jk) mod q.
REQ-020 Arithmetic: q odd, 2 < q < 2^DATA_SIZE_ARB; all inputs < q; every intermediate and output fully reduced to [0,q-1]; products held at 2*DATA_SIZE_ARB bits before reduction.
REQ-021 Computation: in-place iterative radix-2 butterflies over a single N-word data RAM, bit-reversal handled internally; input and output both natural order.
REQ-022 done pulses exactly one cycle no later than N/2*RING_DEPTH*4 + 2N + 64 cycles after the start cycle.
REQ-023 dout carries X[0..N-1] on the N consecutive cycles starting the cycle after done; then IDLE with dout 0.
REQ-024 Data RAM and tables persist across operations; a new load_data is required before each transform; transform without prior load operates on current RAM contents.
REQ-025 Back-to-back: a command pulse on the cycle after the last output word is accepted.

Reset
REQ-026 reset low at a rising edge forces IDLE, done=0, dout=0, clears counters; applies mid-load, mid-compute, mid-output (operation aborted, no done).
REQ-027 Table and data RAM contents are not cleared by reset.

Structure
REQ-028 Shared package: DATA_SIZE_ARB, RING_DEPTH, PE_DEPTH, derived RING_SIZE and TW constants, state encoding.
REQ-029 One sub-module: mod_mul (a*b mod q, fixed pipeline latency, also used for n_inv scaling); add/sub mod q inline.

Verification (N=8, q=17, w=2, w^-1=9, n_inv=15, TW=8; W=1,2,4,8,x,x,x,x; WINV=1,9,13,15,x,x,x,x)
REQ-030 Load tables, load a=[1,0,0,0,0,0,0,0], start -> done, then dout 1,1,1,1,1,1,1,1.
REQ-031 Load a=[0,1,0,0,0,0,0,0], start -> dout 1,2,4,8,16,15,13,9.
REQ-032 Load a=[1,1,1,1,1,1,1,1], start_intt -> dout 1,0,0,0,0,0,0,0.
REQ-033 Load a=[1,2,4,8,16,15,13,9], start_intt -> dout 0,1,0,0,0,0,0,0 (round trip).
REQ-034 Reset low mid-COMPUTE -> no done, dout 0; reload data, start -> correct result, tables intact.
REQ-035 start pulsed during LOAD_D and load_w pulsed during OUTPUT -> ignored; stream and results unchanged.
